// File: rtl/tacho_bcd_display.sv
// Captures a binary pulse count, converts it to four BCD digits with a serial double-dabble engine,
// and scans the digits onto a four-digit active-low seven-segment display with blanking and overflow dp.
module tacho_bcd_display #(
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [VALUE_W-1:0] value,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [3:0]         an,
    output logic               busy,
    output logic               overflow
);
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [VALUE_W-1:0] MAX_VAL  = VALUE_W'(9999);
    localparam logic [REF_W-1:0]   REF_LAST = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [VALUE_W-1:0] operand_q, operand_d;
    logic [15:0]        scratch_q, scratch_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic [15:0]        disp_q, disp_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic [15:0]        adj;

    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         nib;
    logic               blank;

    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        operand_d  = operand_q;
        scratch_d  = scratch_q;
        pend_ovf_d = pend_ovf_q;
        disp_d     = disp_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        adj        = '0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = CONV;
                    bit_cnt_d = CNT_W'(VALUE_W - 1);
                    scratch_d = '0;
                    busy_d    = 1'b1;
                    if (value > MAX_VAL) begin
                        operand_d  = MAX_VAL;
                        pend_ovf_d = 1'b1;
                    end else begin
                        operand_d  = value;
                        pend_ovf_d = 1'b0;
                    end
                end
            end
            CONV: begin
                // Adjust nibbles first, then shift the next operand MSB into the scratch.
                adj       = add3(scratch_q);
                scratch_d = {adj[14:0], operand_q[VALUE_W-1]};
                operand_d = operand_q << 1;
                if (bit_cnt_q == '0) state_d = UPDATE;
                else                 bit_cnt_d = bit_cnt_q - 1'b1;
            end
            UPDATE: begin
                disp_d     = scratch_q;
                overflow_d = pend_ovf_q;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        an_d      = an_q;
        seg_d     = seg_q;
        dp_d      = dp_q;
        nib       = '0;
        blank     = 1'b0;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
            nib       = disp_q[{idx_d, 2'b00} +: 4];
            case (idx_d)
                2'd1:    blank = (disp_q[15:4] == '0);
                2'd2:    blank = (disp_q[15:8] == '0);
                2'd3:    blank = (disp_q[15:12] == '0);
                default: blank = 1'b0;
            endcase
            an_d  = ~(4'b0001 << idx_d);
            seg_d = blank ? 7'b1111111 : seg_code(nib);
            dp_d  = ~overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            operand_q  <= '0;
            scratch_q  <= '0;
            pend_ovf_q <= 1'b0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            ref_cnt_q  <= '0;
            idx_q      <= 2'd3;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            operand_q  <= operand_d;
            scratch_q  <= scratch_d;
            pend_ovf_q <= pend_ovf_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            ref_cnt_q  <= ref_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
